// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds, a read-valid strobe and sticky
// overflow/underflow flags. Every status output is registered and derived
// from the next-state pointers, so it lines up with the updated count.
module fifo_sync_param #(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 16,
  parameter  int AF_LEVEL = DEPTH - 2,
  parameter  int AE_LEVEL = 2,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_en_i,
  input  logic             err_clr_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rd_valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] AF_THR = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_THR = CW'(AE_LEVEL);

  // Reject configurations the pointer scheme or thresholds cannot support.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two and at least 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_sync_param: WIDTH must be at least 1");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_thresholds
    $error("fifo_sync_param: AE_LEVEL must be strictly below AF_LEVEL");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic [AW:0]   wr_ptr_d;
  logic [AW:0]   rd_ptr_d;
  logic [CW-1:0] count_d;
  logic          wr_acc;
  logic          rd_acc;
  logic          full_d;
  logic          empty_d;
  logic          ovf_evt;
  logic          udf_evt;

  // Decide which requests are accepted this cycle and derive next-state status.
  always_comb begin
    wr_acc   = wr_en_i && (!full_o || rd_en_i);
    rd_acc   = rd_en_i && !empty_o;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_acc};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_acc};
    count_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    ovf_evt  = wr_en_i && full_o && !rd_en_i;
    udf_evt  = rd_en_i && empty_o;
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  // Pointers, registered status and sticky error flags; a new error beats a clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_o        <= '0;
      full_o         <= 1'b0;
      empty_o        <= 1'b1;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_o        <= count_d;
      full_o         <= full_d;
      empty_o        <= empty_d;
      almost_full_o  <= (count_d >= AF_THR);
      almost_empty_o <= (count_d <= AE_THR);
      overflow_o     <= ovf_evt || (overflow_o && !err_clr_i);
      underflow_o    <= udf_evt || (underflow_o && !err_clr_i);
    end
  end

  // Registered read port: one-cycle latency, data held when no read is accepted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_o    <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_acc;
      if (rd_acc) begin
        rdata_o <= mem[rd_ptr_q[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed checks of fifo_sync_param in the default
// 8x16 configuration and in a 32x4 configuration with custom thresholds.
module tb_fifo_sync_param;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        wr_en_a, rd_en_a, clr_a;
  logic [7:0]  wdata_a, rdata_a;
  logic        rv_a, full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
  logic [4:0]  count_a;

  logic        wr_en_b, rd_en_b, clr_b;
  logic [31:0] wdata_b, rdata_b;
  logic        rv_b, full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
  logic [2:0]  count_b;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] d;
  logic [31:0] exp_w;
  logic [7:0]  sb_a [$];
  logic [31:0] sb_b [$];

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  fifo_sync_param #(.WIDTH(8), .DEPTH(16)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .wr_en_i(wr_en_a), .wdata_i(wdata_a),
    .rd_en_i(rd_en_a), .err_clr_i(clr_a), .rdata_o(rdata_a), .rd_valid_o(rv_a),
    .full_o(full_a), .empty_o(empty_a), .almost_full_o(af_a),
    .almost_empty_o(ae_a), .count_o(count_a), .overflow_o(ovf_a),
    .underflow_o(udf_a)
  );

  fifo_sync_param #(.WIDTH(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .wr_en_i(wr_en_b), .wdata_i(wdata_b),
    .rd_en_i(rd_en_b), .err_clr_i(clr_b), .rdata_o(rdata_b), .rd_valid_o(rv_b),
    .full_o(full_b), .empty_o(empty_b), .almost_full_o(af_b),
    .almost_empty_o(ae_b), .count_o(count_b), .overflow_o(ovf_b),
    .underflow_o(udf_b)
  );

  // Drive one cycle of requests on the selected FIFO, then sample 1 ns after the edge.
  task automatic applyStimulus(input bit sel_b, input bit wr, input logic [31:0] wd,
                               input bit rd, input bit clr);
    if (sel_b) begin
      wr_en_b = wr; wdata_b = wd; rd_en_b = rd; clr_b = clr;
    end else begin
      wr_en_a = wr; wdata_a = wd[7:0]; rd_en_a = rd; clr_a = clr;
    end
    @(posedge clk);
    #1;
    wr_en_a = 1'b0; rd_en_a = 1'b0; clr_a = 1'b0;
    wr_en_b = 1'b0; rd_en_b = 1'b0; clr_b = 1'b0;
  endtask

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en_a = 1'b0; rd_en_a = 1'b0; clr_a = 1'b0; wdata_a = '0;
    wr_en_b = 1'b0; rd_en_b = 1'b0; clr_b = 1'b0; wdata_b = '0;
    #12;

    $display("[TB] reset state");
    checkOutput("rst_count", 32'(count_a), 0);
    checkOutput("rst_empty", 32'(empty_a), 1);
    checkOutput("rst_ae", 32'(ae_a), 1);
    checkOutput("rst_full", 32'(full_a), 0);
    checkOutput("rst_af", 32'(af_a), 0);
    checkOutput("rst_rdata", 32'(rdata_a), 0);
    checkOutput("rst_rv", 32'(rv_a), 0);
    checkOutput("rst_ovf", 32'(ovf_a), 0);
    checkOutput("rst_udf", 32'(udf_a), 0);
    checkOutput("rst_b_count", 32'(count_b), 0);
    checkOutput("rst_b_empty", 32'(empty_b), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] fill 0x01..0x10");
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(0, 1, 32'(i), 0, 0);
      checkOutput("fill_count", 32'(count_a), 32'(i));
      checkOutput("fill_af", 32'(af_a), 32'(i >= 14));
      checkOutput("fill_full", 32'(full_a), 32'(i == 16));
      checkOutput("fill_empty", 32'(empty_a), 0);
      checkOutput("fill_ae", 32'(ae_a), 32'(i <= 2));
    end

    $display("[TB] overflow write");
    applyStimulus(0, 1, 32'hAA, 0, 0);
    checkOutput("ovf_flag", 32'(ovf_a), 1);
    checkOutput("ovf_count", 32'(count_a), 16);
    checkOutput("ovf_full", 32'(full_a), 1);

    $display("[TB] drain 16");
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("drain_rdata", 32'(rdata_a), 32'(i));
      checkOutput("drain_rv", 32'(rv_a), 1);
      checkOutput("drain_count", 32'(count_a), 32'(16 - i));
      checkOutput("drain_ovf_sticky", 32'(ovf_a), 1);
    end
    checkOutput("drain_empty", 32'(empty_a), 1);
    checkOutput("drain_ae", 32'(ae_a), 1);
    checkOutput("drain_full", 32'(full_a), 0);

    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("idle_rv", 32'(rv_a), 0);
    checkOutput("idle_rdata_hold", 32'(rdata_a), 32'h10);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("clr_ovf", 32'(ovf_a), 0);

    $display("[TB] simultaneous read/write at full");
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 32'(8'h21 + i), 0, 0);
    checkOutput("refill_full", 32'(full_a), 1);
    applyStimulus(0, 1, 32'h55, 1, 0);
    checkOutput("rw_full_rdata", 32'(rdata_a), 32'h21);
    checkOutput("rw_full_rv", 32'(rv_a), 1);
    checkOutput("rw_full_count", 32'(count_a), 16);
    checkOutput("rw_full_full", 32'(full_a), 1);
    checkOutput("rw_full_ovf", 32'(ovf_a), 0);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      exp_w = (i <= 15) ? 32'(8'h21 + i) : 32'h55;
      checkOutput("rw_full_drain", 32'(rdata_a), exp_w);
      checkOutput("rw_full_drain_count", 32'(count_a), 32'(16 - i));
    end
    checkOutput("rw_full_empty", 32'(empty_a), 1);

    $display("[TB] underflow handling");
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("udf_flag", 32'(udf_a), 1);
    checkOutput("udf_rv", 32'(rv_a), 0);
    checkOutput("udf_rdata_hold", 32'(rdata_a), 32'h55);
    checkOutput("udf_count", 32'(count_a), 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("udf_clr", 32'(udf_a), 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("udf_clr_vs_new", 32'(udf_a), 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("udf_clr2", 32'(udf_a), 0);
    applyStimulus(0, 1, 32'h77, 1, 0);
    checkOutput("rw_empty_count", 32'(count_a), 1);
    checkOutput("rw_empty_udf", 32'(udf_a), 1);
    checkOutput("rw_empty_rv", 32'(rv_a), 0);
    checkOutput("rw_empty_nobypass", 32'(rdata_a), 32'h55);
    checkOutput("rw_empty_empty", 32'(empty_a), 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("rw_empty_read", 32'(rdata_a), 32'h77);
    checkOutput("rw_empty_read_count", 32'(count_a), 0);
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] wrap-around with random data");
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 10; k++) begin
        d = $urandom;
        sb_a.push_back(d[7:0]);
        applyStimulus(0, 1, d, 0, 0);
        checkOutput("wrap_wr_count", 32'(count_a), 32'(k + 1));
      end
      checkOutput("wrap_af", 32'(af_a), 0);
      for (int k = 0; k < 10; k++) begin
        applyStimulus(0, 0, 0, 1, 0);
        exp_w = 32'(sb_a.pop_front());
        checkOutput("wrap_rdata", 32'(rdata_a), exp_w);
        checkOutput("wrap_rd_count", 32'(count_a), 32'(9 - k));
      end
      checkOutput("wrap_empty", 32'(empty_a), 1);
    end

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(0, 0, 0, 1, 0);
    for (int k = 0; k < 7; k++) applyStimulus(0, 1, 32'(8'h60 + k), 0, 0);
    checkOutput("mid_pre_count", 32'(count_a), 7);
    checkOutput("mid_pre_udf", 32'(udf_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_count", 32'(count_a), 0);
    checkOutput("mid_empty", 32'(empty_a), 1);
    checkOutput("mid_ovf", 32'(ovf_a), 0);
    checkOutput("mid_udf", 32'(udf_a), 0);
    checkOutput("mid_rdata", 32'(rdata_a), 0);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 1, 32'h99, 0, 0);
    checkOutput("post_rst_count", 32'(count_a), 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("post_rst_rdata", 32'(rdata_a), 32'h99);
    checkOutput("post_rst_empty", 32'(empty_a), 1);

    $display("[TB] 32x4 instance");
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 1, 32'hDEAD0000 + 32'(k), 0, 0);
      checkOutput("b_fill_count", 32'(count_b), 32'(k));
      checkOutput("b_fill_af", 32'(af_b), 32'(k >= 3));
      checkOutput("b_fill_ae", 32'(ae_b), 32'(k <= 1));
      checkOutput("b_fill_full", 32'(full_b), 32'(k == 4));
    end
    applyStimulus(1, 1, 32'h12345678, 0, 0);
    checkOutput("b_ovf", 32'(ovf_b), 1);
    checkOutput("b_ovf_count", 32'(count_b), 4);
    applyStimulus(1, 1, 32'hCAFEF00D, 1, 0);
    checkOutput("b_rw_full_rdata", rdata_b, 32'hDEAD0001);
    checkOutput("b_rw_full_count", 32'(count_b), 4);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 0, 0, 1, 0);
      exp_w = (k <= 3) ? 32'hDEAD0001 + 32'(k) : 32'hCAFEF00D;
      checkOutput("b_drain_rdata", rdata_b, exp_w);
      checkOutput("b_drain_count", 32'(count_b), 32'(4 - k));
    end
    checkOutput("b_empty", 32'(empty_b), 1);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("b_udf", 32'(udf_b), 1);
    checkOutput("b_udf_rv", 32'(rv_b), 0);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        d = $urandom;
        sb_b.push_back(d);
        applyStimulus(1, 1, d, 0, 0);
      end
      checkOutput("b_wrap_count", 32'(count_b), 3);
      for (int k = 0; k < 3; k++) begin
        applyStimulus(1, 0, 0, 1, 0);
        exp_w = sb_b.pop_front();
        checkOutput("b_wrap_rdata", rdata_b, exp_w);
      end
    end
    for (int k = 0; k < 3; k++) applyStimulus(1, 1, 32'(k), 0, 0);
    checkOutput("b_mid_pre_count", 32'(count_b), 3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("b_mid_count", 32'(count_b), 0);
    checkOutput("b_mid_empty", 32'(empty_b), 1);
    checkOutput("b_mid_ovf", 32'(ovf_b), 0);
    checkOutput("b_mid_udf", 32'(udf_b), 0);
    #1;
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
